// File: rtl/alu_op_sequencer.sv
// Issue stage for a combinational ALU: buffers commands in a FIFO, drives one at a
// time onto the ALU lines, captures the result after one settle cycle, hands it off.
module alu_op_sequencer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 4,
    parameter int unsigned SW    = 3,
    parameter int unsigned YW    = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [AW-1:0]              cmd_a,
    input  logic [AW-1:0]              cmd_b,
    input  logic [SW-1:0]              cmd_s,
    output logic [AW-1:0]              alu_a,
    output logic [AW-1:0]              alu_b,
    output logic [SW-1:0]              alu_s,
    input  logic [YW-1:0]              alu_y,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [YW-1:0]              res_y,
    output logic [SW-1:0]              res_s,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       busy
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef struct packed {
        logic [AW-1:0] a;
        logic [AW-1:0] b;
        logic [SW-1:0] s;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, SETTLE, RESULT} state_t;

    cmd_t          mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    state_t        state_q, state_d;
    cmd_t          alu_q, alu_d;
    logic [YW-1:0] res_y_q, res_y_d;
    logic [SW-1:0] res_s_q, res_s_d;
    logic          res_valid_q, res_valid_d;
    logic          push, pop;

    // Full is judged on the registered count only, so a pop never frees a slot early.
    assign cmd_ready = !rst && (count_q < FULL);
    assign push      = cmd_valid && cmd_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        alu_d       = alu_q;
        res_y_d     = res_y_q;
        res_s_d     = res_s_q;
        res_valid_d = res_valid_q;
        unique case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    alu_d   = mem_q[rd_ptr_q];
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                res_y_d     = alu_y;
                res_s_d     = alu_q.s;
                res_valid_d = 1'b1;
                state_d     = RESULT;
            end
            RESULT: begin
                if (res_valid_q && res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= IDLE;
            alu_q       <= '0;
            res_y_q     <= '0;
            res_s_q     <= '0;
            res_valid_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            alu_q       <= alu_d;
            res_y_q     <= res_y_d;
            res_s_q     <= res_s_d;
            res_valid_q <= res_valid_d;
        end
    end

    // Storage needs no reset: entries are only read behind a valid count.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= '{a: cmd_a, b: cmd_b, s: cmd_s};
    end

    assign alu_a      = alu_q.a;
    assign alu_b      = alu_q.b;
    assign alu_s      = alu_q.s;
    assign res_valid  = res_valid_q;
    assign res_y      = res_y_q;
    assign res_s      = res_s_q;
    assign fifo_count = count_q;
    assign busy       = (state_q != IDLE);
endmodule
